// File: rtl/interrupt_sequencer_if.sv
// Request/mask pair between the interrupt controller and the CPU-side sequencer.
// intCPU rises with a valid intID and stays high until intDisabled is seen high.
interface interrupt_sequencer_if;
  logic       intCPU;
  logic [7:0] intID;
  logic       intDisabled;

  modport master (output intCPU, output intID, input intDisabled);
  modport slave  (input intCPU, input intID, output intDisabled);
endinterface

// File: rtl/interrupt_sequencer.sv
// Takes a pending interrupt at an instruction boundary, redirects fetch to the
// vector and masks further requests until the handler's reti has redirected back.
module interrupt_sequencer #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int unsigned VECTOR_ADDR = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  interrupt_sequencer_if.slave  irq,
  input  logic                  boundary,
  input  logic [ADDR_WIDTH-1:0] resume_pc,
  input  logic                  reti_exec,
  output logic                  redirect,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] saved_pc,
  output logic [7:0]            int_id,
  output logic [15:0]           int_count,
  output logic                  spurious_reti,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_RESUME = 2'd2
  } state_t;

  state_t                state, state_nx;
  logic                  dis_nx, redirect_nx, spurious_nx;
  logic [ADDR_WIDTH-1:0] redirect_pc_nx, saved_pc_nx;
  logic [7:0]            int_id_nx;
  logic [15:0]           int_count_nx;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      irq.intDisabled <= 1'b0;
      redirect        <= 1'b0;
      redirect_pc     <= '0;
      saved_pc        <= '0;
      int_id          <= '0;
      int_count       <= '0;
      spurious_reti   <= 1'b0;
    end else begin
      state           <= state_nx;
      irq.intDisabled <= dis_nx;
      redirect        <= redirect_nx;
      redirect_pc     <= redirect_pc_nx;
      saved_pc        <= saved_pc_nx;
      int_id          <= int_id_nx;
      int_count       <= int_count_nx;
      spurious_reti   <= spurious_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    dis_nx         = 1'b0;
    redirect_nx    = 1'b0;
    redirect_pc_nx = redirect_pc;
    saved_pc_nx    = saved_pc;
    int_id_nx      = int_id;
    int_count_nx   = int_count;
    spurious_nx    = spurious_reti;
    case (state)
      S_IDLE: begin
        // A reti here has no handler to return from; flag it even if an interrupt is taken too.
        if (reti_exec) spurious_nx = 1'b1;
        if (irq.intCPU && boundary) begin
          saved_pc_nx    = resume_pc;
          int_id_nx      = irq.intID;
          redirect_nx    = 1'b1;
          redirect_pc_nx = ADDR_WIDTH'(VECTOR_ADDR);
          dis_nx         = 1'b1;
          int_count_nx   = (int_count == 16'hFFFF) ? int_count : int_count + 16'd1;
          state_nx       = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        dis_nx = 1'b1;
        if (reti_exec) begin
          redirect_nx    = 1'b1;
          redirect_pc_nx = saved_pc;
          state_nx       = S_RESUME;
        end
      end
      S_RESUME: begin
        // Mask stays up through this cycle so a new request cannot race the return redirect.
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed and randomized bench for interrupt_sequencer; expected outputs come
// from a cycle model and are queued at drive time, then checked after each edge.
module tb_interrupt_sequencer;
  localparam int W = 91;

  logic        clk = 1'b0;
  logic        reset;
  logic        boundary;
  logic [31:0] resume_pc;
  logic        reti_exec;
  logic        redirect;
  logic [31:0] redirect_pc, saved_pc;
  logic [7:0]  int_id;
  logic [15:0] int_count;
  logic        spurious_reti;
  logic [1:0]  dbg_state;

  interrupt_sequencer_if irq();

  interrupt_sequencer #(.ADDR_WIDTH(32), .VECTOR_ADDR(1)) dut (
    .clk(clk), .reset(reset), .irq(irq), .boundary(boundary),
    .resume_pc(resume_pc), .reti_exec(reti_exec), .redirect(redirect),
    .redirect_pc(redirect_pc), .saved_pc(saved_pc), .int_id(int_id),
    .int_count(int_count), .spurious_reti(spurious_reti), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  // reference model state: 0 idle, 1 active, 2 resume
  int          m_state = 0;
  logic        m_dis = 0, m_redir = 0, m_spur = 0;
  logic [31:0] m_rpc = 0, m_spc = 0;
  logic [7:0]  m_id = 0;
  logic [15:0] m_cnt = 0;

  task automatic model(input logic r, ic, input logic [7:0] id, input logic b,
                       input logic [31:0] pc, input logic rt);
    if (r) begin
      m_state = 0; m_dis = 0; m_redir = 0; m_rpc = 0; m_spc = 0;
      m_id = 0; m_cnt = 0; m_spur = 0;
    end else begin
      m_redir = 0;
      case (m_state)
        0: begin
          m_dis = 0;
          if (rt) m_spur = 1;
          if (ic && b) begin
            m_spc = pc; m_id = id; m_redir = 1; m_rpc = 32'd1; m_dis = 1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_state = 1;
          end
        end
        1: begin
          m_dis = 1;
          if (rt) begin m_redir = 1; m_rpc = m_spc; m_state = 2; end
        end
        default: begin m_dis = 0; m_state = 0; end
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    e = exp_q.pop_front();
    chk("intDisabled",   irq.intDisabled, e[90]);
    chk("redirect",      redirect,        e[89]);
    chk("redirect_pc",   redirect_pc,     e[88:57]);
    chk("saved_pc",      saved_pc,        e[56:25]);
    chk("int_id",        int_id,          e[24:17]);
    chk("int_count",     int_count,       e[16:1]);
    chk("spurious_reti", spurious_reti,   e[0]);
  endtask

  task automatic step(input logic r, ic, input logic [7:0] id, input logic b,
                      input logic [31:0] pc, input logic rt);
    @(negedge clk);
    reset = r; irq.intCPU = ic; irq.intID = id; boundary = b;
    resume_pc = pc; reti_exec = rt;
    model(r, ic, id, b, pc, rt);
    exp_q.push_back({m_dis, m_redir, m_rpc, m_spc, m_id, m_cnt, m_spur});
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_step();
    step(0, 0, 8'd0, 0, 32'h0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1; irq.intCPU = 0; irq.intID = 0; boundary = 0; resume_pc = 0; reti_exec = 0;

    step(1, 0, 8'd0, 0, 32'h0, 0);
    step(1, 0, 8'd0, 0, 32'h0, 0);
    chk("reset_int_count", int_count, 32'd0);

    // basic take, stale request held two cycles
    step(0, 1, 8'd3, 1, 32'h100, 0);
    chk("basic_redirect_pc", redirect_pc, 32'h1);
    chk("basic_saved_pc", saved_pc, 32'h100);
    chk("basic_int_id", int_id, 32'd3);
    step(0, 1, 8'd3, 1, 32'h200, 0);
    step(0, 1, 8'd3, 1, 32'h300, 0);
    chk("stale_count", int_count, 32'd1);
    idle_step();
    // return; RESUME ignores a request; then back-to-back acceptance
    step(0, 0, 8'd0, 0, 32'h0, 1);
    chk("reti_redirect_pc", redirect_pc, 32'h100);
    step(0, 1, 8'd5, 1, 32'h444, 0);
    chk("resume_no_accept", redirect, 32'd0);
    chk("dis_low_after_reti", irq.intDisabled, 32'd0);
    step(0, 1, 8'd5, 1, 32'h500, 0);
    chk("b2b_int_id", int_id, 32'd5);
    chk("b2b_count", int_count, 32'd2);
    step(0, 0, 8'd0, 0, 32'h0, 1);
    idle_step();

    // boundary wait
    for (int i = 0; i < 4; i++) step(0, 1, 8'd7, 0, $urandom_range(0, 32'hFFFF), 0);
    step(0, 1, 8'd7, 1, 32'h2A0, 0);
    chk("bwait_saved_pc", saved_pc, 32'h2A0);
    step(0, 0, 8'd0, 0, 32'h0, 1);
    idle_step();

    // spurious reti is sticky; reti + request together still takes it
    step(0, 0, 8'd0, 0, 32'h0, 1);
    chk("spurious_set", spurious_reti, 32'd1);
    idle_step();
    idle_step();
    step(0, 1, 8'd2, 1, 32'h600, 1);
    chk("reti_and_take", redirect, 32'd1);

    // reset mid-ACTIVE, then a reti is spurious
    step(1, 0, 8'd0, 0, 32'h0, 0);
    chk("rst_mid_dis", irq.intDisabled, 32'd0);
    chk("rst_mid_spur", spurious_reti, 32'd0);
    step(0, 0, 8'd0, 0, 32'h0, 1);
    chk("rst_then_spur", spurious_reti, 32'd1);

    // saturation
    @(negedge clk);
    force dut.int_count = 16'hFFFE;
    #1;
    release dut.int_count;
    m_cnt = 16'hFFFE;
    step(0, 1, 8'd4, 1, 32'h700, 0);
    chk("sat_reach", int_count, 32'hFFFF);
    step(0, 0, 8'd0, 0, 32'h0, 1);
    idle_step();
    step(0, 1, 8'd6, 1, 32'h800, 0);
    chk("sat_hold", int_count, 32'hFFFF);
    step(0, 0, 8'd0, 0, 32'h0, 1);
    idle_step();

    // randomized traffic against the model
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 39) == 0), $urandom_range(0, 1), 8'($urandom_range(1, 8)),
           $urandom_range(0, 1), $urandom(), ($urandom_range(0, 4) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

CPU-side responder for the interrupt request/acknowledge protocol: accepts `intCPU`/`intID` from the interrupt controller and takes the interrupt only at a safe instruction boundary. On taking it, the block saves the resume PC, redirects fetch to the interrupt vector and holds `intDisabled` high until the handler's `reti` commits. It sits between the interrupt controller and the CPU fetch/writeback stages. It is the sole driver of the controller's `intDisabled` input.

## Interface
- `ADDR_WIDTH`, 32, width of PCs.
- `VECTOR_ADDR`, 1, handler entry address.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `intCPU`  in  1  interrupt request from the controller; stays high until `intDisabled` is seen high.
- `intID`  in  8  ID of the pending interrupt (1..8); valid while `intCPU` is high.
- `boundary`  in  1  CPU is at an interruptible point this cycle (valid instruction committing, no stall, no pending branch redirect).
- `resume_pc`  in  ADDR_WIDTH  PC at which execution continues if interrupted this cycle.
- `reti_exec`  in  1  a `reti` instruction commits this cycle.
- `intDisabled`  out  1  interrupts masked; to controller and CPU status.
- `redirect`  out  1  one-cycle fetch redirect strobe.
- `redirect_pc`  out  ADDR_WIDTH  redirect target; valid while `redirect` is high.
- `saved_pc`  out  ADDR_WIDTH  latched resume PC.
- `int_id`  out  8  latched ID of the interrupt being serviced; software-readable.
- `int_count`  out  16  number of interrupts taken; saturates at 0xFFFF.
- `spurious_reti`  out  1  sticky flag: `reti` committed outside ACTIVE.

## Operation
- All outputs are registered. Reset values: `intDisabled`=0, `redirect`=0, `redirect_pc`=0, `saved_pc`=0, `int_id`=0, `int_count`=0, `spurious_reti`=0. Reset returns the FSM to IDLE.
- States: IDLE, ACTIVE, RESUME. The encoding is free.
- IDLE:
  - `intDisabled`=0.
  - If `intCPU` and `boundary` are both high at an edge: `saved_pc`<=`resume_pc`, `int_id`<=`intID`, `redirect`<=1, `redirect_pc`<=`VECTOR_ADDR`, `intDisabled`<=1, `int_count`<=`int_count`+1 (saturating), go to ACTIVE.
  - `intCPU` without `boundary`: wait; nothing latched.
  - `reti_exec` in IDLE: no redirect; set `spurious_reti`<=1.
  - If `reti_exec`, `intCPU` and `boundary` are all high, the interrupt is taken and `spurious_reti` is still set.
- ACTIVE:
  - `intDisabled`=1.
  - `intCPU` is ignored. It is expected to stay high for one cycle after entry, until the controller clears it.
  - `reti_exec`: `redirect`<=1, `redirect_pc`<=`saved_pc`, go to RESUME.
- RESUME:
  - One cycle with `intDisabled` still 1, so no new request can race the return redirect.
  - Then go to IDLE with `intDisabled`<=0. Inputs are ignored in this state.
- `redirect` is high for exactly one cycle per transition into ACTIVE or RESUME; otherwise it is 0.
- `redirect_pc` holds its last value when `redirect`=0.
- There is no nesting. A second interrupt is serviced only after returning to IDLE.
- `int_id` and `saved_pc` hold until the next acceptance.
- `spurious_reti` clears only on reset.

## Timing
- Accept edge k → `redirect` and `intDisabled` high in cycle k+1. `redirect` drops at k+2.
- `reti_exec` at edge r → `redirect` high in cycle r+1 with `saved_pc`; `intDisabled` falls at edge r+2.
- Minimum spacing from `reti` commit to the next acceptance: 3 edges. The controller needs ≥1 more edge to re-raise `intCPU`.
- Reset mid-ACTIVE or mid-RESUME: IDLE next cycle, `intDisabled`=0, any pending redirect cancelled.

## Test plan
- Basic take/return:
  - Stimulus: `intCPU`=1, `intID`=3, `boundary`=1, `resume_pc`=0x100.
  - Required: next cycle `redirect`=1, `redirect_pc`=1, `intDisabled`=1, `int_id`=3, `saved_pc`=0x100, `int_count`=1.
  - Then `reti_exec` → `redirect`=1 with `redirect_pc`=0x100. `intDisabled` is 0 two edges after `reti`.
- Boundary wait:
  - Stimulus: `intCPU` high with `boundary`=0 for 4 cycles, then `boundary`=1 with `resume_pc`=0x2A0.
  - Required: no `redirect` during the wait. Acceptance occurs only on the `boundary` edge; `saved_pc`=0x2A0.
- Stale request ignored:
  - Stimulus: hold `intCPU`=1 for 2 cycles after acceptance.
  - Required: exactly one `redirect`; `int_count`=1.
- Spurious `reti`:
  - Stimulus: `reti_exec` in IDLE.
  - Required: `redirect`=0, `spurious_reti`=1, sticky until reset.
- Back-to-back interrupts:
  - Stimulus: `intCPU` re-asserted with `intID`=5 in the first IDLE cycle after RESUME.
  - Required: accepted, `int_id`=5, `int_count`=2.
  - Also: no acceptance while in RESUME, even with `intCPU` high.
- Reset mid-handler:
  - Stimulus: assert `reset` in ACTIVE.
  - Required: next cycle all outputs 0, FSM in IDLE. A subsequent `reti_exec` sets `spurious_reti`.
- Saturation:
  - Stimulus: preload 65535 interrupts (or force the counter), then take one more.
  - Required: `int_count` stays 0xFFFF.
